// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous FIFO: turns rd_en/empty/registered dout
// into a valid/ready stream with packet framing via a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int DWIDTH  = 16,
  parameter int PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last
);

  localparam int WCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [WCW-1:0] WCNT_MAX = WCW'(PKT_LEN - 1);

  logic [1:0]        occ_reg, occ_next;
  logic              inflight_reg, inflight_next;
  logic [DWIDTH-1:0] head_reg, head_next;
  logic [DWIDTH-1:0] tail_reg, tail_next;
  logic [WCW-1:0]    wcnt_reg, wcnt_next;

  logic       pop;
  logic [1:0] occ_after;
  logic [1:0] committed;

  always_comb begin
    pop       = (occ_reg != 2'd0) && out_ready;
    occ_after = occ_reg - {1'b0, pop};
    // Words already owned by the buffer once this cycle's pop and capture land.
    committed = occ_after + {1'b0, inflight_reg};

    fifo_rd_en    = !rst && !fifo_empty && (committed < 2'd2);
    inflight_next = fifo_rd_en && !fifo_empty;
    occ_next      = committed;

    head_next = head_reg;
    tail_next = tail_reg;
    if (pop && (occ_reg == 2'd2)) begin
      head_next = tail_reg;
    end
    if (inflight_reg) begin
      if (occ_after == 2'd0) begin
        head_next = fifo_dout;
      end else begin
        tail_next = fifo_dout;
      end
    end

    wcnt_next = wcnt_reg;
    if (pop) begin
      wcnt_next = (wcnt_reg == WCNT_MAX) ? '0 : wcnt_reg + WCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg      <= 2'd0;
      inflight_reg <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
      wcnt_reg     <= '0;
    end else begin
      occ_reg      <= occ_next;
      inflight_reg <= inflight_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      wcnt_reg     <= wcnt_next;
    end
  end

  // Outputs come straight from registers; fifo_dout never reaches them combinationally.
  assign out_valid = (occ_reg != 2'd0);
  assign out_data  = head_reg;
  assign out_last  = out_valid && (wcnt_reg == WCNT_MAX);

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter for the synchronous FIFO. It drains words from the FIFO's `rd_en`/`empty`/registered-`dout` port and presents them as a valid/ready stream with `out_last` framing. A 2-entry skid buffer absorbs the FIFO's one-cycle read latency so the stream sustains one word per clock under continuous `out_ready`. It sits between the FIFO read port and any downstream consumer that applies backpressure.

## Interface
- `DWIDTH`, 16: data word width; must match the FIFO `DWIDTH`.
- `PKT_LEN`, 4: words per packet, ≥1; `out_last` marks every `PKT_LEN`-th delivered word.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO read request; a read is accepted when `fifo_rd_en && !fifo_empty`.
- `fifo_dout`  in  DWIDTH  FIFO read data, valid the cycle after an accepted read.
- `out_valid`  out  1  stream word available.
- `out_ready`  in  1  consumer accepts the word; transfer ("pop") = `out_valid && out_ready`.
- `out_data`  out  DWIDTH  stream word.
- `out_last`  out  1  final word of a packet; meaningful only with `out_valid`.

## Operation
- State:
  - `occ`: buffer occupancy, 0..2.
  - `inflight`: a read was accepted last cycle, so `fifo_dout` is valid this cycle.
  - Head/tail data registers.
  - `wcnt`: packet word counter, 0..`PKT_LEN`-1.
- `inflight` next value = `fifo_rd_en && !fifo_empty`.
- Read issue (combinational): `fifo_rd_en = !rst && !fifo_empty && (occ + inflight - pop) < 2`.
  - This never overcommits the buffer.
  - `occ + inflight` ≤ 2 at all times.
- Capture: when `inflight` is 1, `fifo_dout` is written into the buffer at the clock edge.
  - It goes to the head if the buffer is empty after this cycle's pop; otherwise to the tail.
- Pop: the head is consumed and the tail shifts to the head, in the same edge as any capture.
- `occ` next value = `occ + inflight - pop`.
- `out_valid = (occ != 0)` and `out_data = head`. Both are driven from registers, with no combinational path from `fifo_dout`.
- Data order is strictly the FIFO read order. No word is dropped or duplicated.
- `out_last = out_valid && (wcnt == PKT_LEN-1)`.
  - On pop, `wcnt` increments, or wraps to 0 after `PKT_LEN-1`.
  - With `PKT_LEN`=1, `out_last` equals `out_valid`.
- While `out_valid` is held and `out_ready` is low, `out_data` and `out_last` stay stable.
- Reset (asynchronous, at any time):
  - Clears `occ`, `inflight` and `wcnt`; zeroes the data registers.
  - `out_valid`=0, `out_last`=0, `out_data`=0, `fifo_rd_en`=0 while `rst` is high.
  - A read in flight at reset is discarded; the FIFO is reset together with this block.

## Timing
- Latency: read accepted in cycle N → `fifo_dout` valid in N+1 → `out_valid` high in N+2.
- Throughput: with `out_ready` held high and the FIFO non-empty, one pop per cycle after the first word. Steady state is `occ`=1, `inflight`=1.
- Backpressure: with `out_ready` low, at most 2 words are held. `fifo_rd_en` drops within the cycle where `occ + inflight` reaches 2.
- Simultaneous capture and pop at `occ`=1: the head is replaced by the incoming word and `occ` stays 1.
- Simultaneous capture and pop at `occ`=2: the tail moves to the head, the new word goes to the tail, and `occ` stays 2.
- FIFO going empty mid-stream: `fifo_rd_en` deasserts. The buffered words still drain, then `out_valid` falls.
- First cycle after `rst` deasserts: `fifo_rd_en` may assert if `!fifo_empty`.

## Test plan
- **Reset values:** reset with FIFO preloaded `0x0001..0x0004` → all outputs 0 during reset. After release, `out_valid` rises 2 cycles after the first `fifo_rd_en`.
- **Streaming:** FIFO holds `0x0011..0x0018`, `out_ready` held high → 8 consecutive pops in order, one per cycle. `out_last` is high on `0x0014` and `0x0018`.
- **Backpressure:** 6 words queued, `out_ready` low for 10 cycles → exactly 2 accepted reads, `out_data` stable at the first word. After release, all 6 words arrive in order with no gaps beyond the initial latency.
- **Random stall:** 64 random words, `out_ready` randomized at 50% → the scoreboard matches order and count, `occ + inflight` never exceeds 2, and `out_last` appears every 4th pop.
- **Reset mid-stream:** reset asserted after 3 of 8 words are popped, with a read in flight → outputs clear asynchronously. After refill with `0x00A0..0x00A3`, the stream restarts with `wcnt`=0 and `out_last` on `0x00A3`.
- **PKT_LEN=1:** 3 words → `out_last` is high on every pop.
